thread_issue: RTL and testbench

//  Upstream neighbour of the Dispatch stage: holds per-thread execution contexts and injects
//  one pipeline_pass_structure per cycle into the Dispatch inState port. Round-robin schedules

---
 rtl/thread_issue_pkg.sv | 54 +++++
 rtl/thread_issue_if.sv | 31 +++
 rtl/thread_issue_rr_arbiter.sv | 29 ++
 rtl/thread_issue.sv | 131 +++++++++++++
 tb/tb_thread_issue.sv | 289 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/thread_issue_pkg.sv
// Shared types for the thread issue block: thread/FSM states, the
// pipeline pass structure and helpers that build issue/launch contexts.
package thread_issue_pkg;

    localparam int NUM_THREADS_DEF = 8;
    localparam int THREAD_ID_W = $clog2(NUM_THREADS_DEF);
    localparam int SYS_ID_W = 8;

    typedef enum logic [1:0] {
        T_IDLE,
        T_READY,
        T_INFLIGHT,
        T_DONE
    } thread_state_e;

    typedef enum logic {
        S_IDLE,
        S_RUN
    } issue_fsm_e;

    typedef struct packed {
        logic                active_thread;
        logic [SYS_ID_W-1:0] id;
    } system_t;

    typedef struct packed {
        system_t     system;
        logic [31:0] pc;
        logic [31:0] data;
    } pipeline_pass_structure;

    function automatic pipeline_pass_structure build_issue(
        input pipeline_pass_structure ctx,
        input logic [SYS_ID_W-1:0]    id
    );
        pipeline_pass_structure s;
        s = ctx;
        s.system.active_thread = 1'b1;
        s.system.id = id;
        return s;
    endfunction

    function automatic pipeline_pass_structure launch_ctx(
        input logic [31:0]         pc,
        input logic [SYS_ID_W-1:0] id
    );
        pipeline_pass_structure s;
        s = '0;
        s.pc = pc;
        s.system.id = id;
        return s;
    endfunction

endpackage

// File: rtl/thread_issue_if.sv
// Control/data bundle between the thread issue block and its environment.
// The slave side is the issue block itself.
interface thread_issue_if #(
    parameter int NUM_THREADS = 8,
    parameter int CNT_W = 32
);
    import thread_issue_pkg::*;

    logic                   start;
    logic [NUM_THREADS-1:0] launch_mask;
    logic                   issue_en;
    pipeline_pass_structure ret_state;
    logic                   ret_halt;
    pipeline_pass_structure outState;
    logic                   busy;
    logic                   done;
    logic                   err_ret;
    logic [CNT_W-1:0]       issue_count;
    logic [CNT_W-1:0]       run_cycles;

    modport master (
        output start, launch_mask, issue_en, ret_state, ret_halt,
        input  outState, busy, done, err_ret, issue_count, run_cycles
    );

    modport slave (
        input  start, launch_mask, issue_en, ret_state, ret_halt,
        output outState, busy, done, err_ret, issue_count, run_cycles
    );

endinterface

// File: rtl/thread_issue_rr_arbiter.sv
// Combinational round-robin picker: first request at or after ptr,
// wrapping past the top index.
module rr_arbiter #(
    parameter int N = 8,
    parameter int TW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [TW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic          valid,
    output logic [TW-1:0] idx
);

    always_comb begin
        gnt = '0;
        valid = 1'b0;
        idx = '0;
        for (int i = 0; i < N; i++) begin
            logic [TW-1:0] c;
            c = ptr + TW'(i);
            if (!valid && req[c]) begin
                valid = 1'b1;
                idx = c;
            end
        end
        gnt[idx] = valid;
    end

endmodule

// File: rtl/thread_issue.sv
// Holds per-thread contexts, round-robin issues READY threads toward
// Dispatch and recirculates/retires contexts returned from the tail.
module thread_issue #(
    parameter int          NUM_THREADS = 8,
    parameter logic [31:0] addressStart = 32'h0,
    parameter int          CNT_W = 32
) (
    input logic           clk,
    input logic           rst,
    thread_issue_if.slave bus
);
    import thread_issue_pkg::*;

    localparam int TW = $clog2(NUM_THREADS);

    issue_fsm_e             fsm;
    thread_state_e          tstate [NUM_THREADS];
    pipeline_pass_structure ctx [NUM_THREADS];
    logic [TW-1:0]          rr_ptr;

    logic [NUM_THREADS-1:0] ready_vec;
    logic [NUM_THREADS-1:0] done_vec;
    logic [NUM_THREADS-1:0] gnt_oh;
    logic                   gnt_valid;
    logic [TW-1:0]          gnt_idx;

    always_comb begin
        ready_vec = '0;
        done_vec = '0;
        for (int t = 0; t < NUM_THREADS; t++) begin
            ready_vec[t] = (tstate[t] == T_READY);
            done_vec[t] = (tstate[t] == T_DONE);
        end
    end

    rr_arbiter #(
        .N (NUM_THREADS),
        .TW(TW)
    ) u_arb (
        .req  (ready_vec),
        .ptr  (rr_ptr),
        .gnt  (gnt_oh),
        .valid(gnt_valid),
        .idx  (gnt_idx)
    );

    logic          do_issue;
    logic          launch;
    logic          all_done;
    logic          ret_valid;
    logic [TW-1:0] ret_id;

    assign do_issue = (fsm == S_RUN) && bus.issue_en && gnt_valid;
    assign launch = (fsm == S_IDLE) && bus.start && (|bus.launch_mask);
    assign all_done = &done_vec;
    assign ret_valid = bus.ret_state.system.active_thread;
    assign ret_id = bus.ret_state.system.id[TW-1:0];
    assign bus.busy = (fsm != S_IDLE);

    always_ff @(posedge clk) begin
        if (!rst) begin
            fsm <= S_IDLE;
            rr_ptr <= '0;
            bus.outState <= '0;
            bus.done <= 1'b0;
            bus.err_ret <= 1'b0;
            bus.issue_count <= '0;
            bus.run_cycles <= '0;
            for (int t = 0; t < NUM_THREADS; t++) begin
                tstate[t] <= T_IDLE;
                ctx[t] <= '0;
            end
        end else begin
            bus.done <= 1'b0;
            unique case (fsm)
                S_IDLE: begin
                    if (launch) begin
                        fsm <= S_RUN;
                        rr_ptr <= '0;
                        bus.issue_count <= '0;
                        bus.run_cycles <= '0;
                        // Unlaunched threads count as finished for this run
                        for (int t = 0; t < NUM_THREADS; t++) begin
                            if (bus.launch_mask[t]) begin
                                tstate[t] <= T_READY;
                                ctx[t] <= launch_ctx(addressStart, SYS_ID_W'(t));
                            end else begin
                                tstate[t] <= T_DONE;
                            end
                        end
                    end
                end
                S_RUN: begin
                    if (~&bus.run_cycles)
                        bus.run_cycles <= bus.run_cycles + CNT_W'(1);
                    if (all_done) begin
                        fsm <= S_IDLE;
                        bus.done <= 1'b1;
                    end
                end
                default: fsm <= S_IDLE;
            endcase

            if (do_issue) begin
                bus.outState <= build_issue(ctx[gnt_idx], SYS_ID_W'(gnt_idx));
                rr_ptr <= gnt_idx + TW'(1);
                if (~&bus.issue_count)
                    bus.issue_count <= bus.issue_count + CNT_W'(1);
                for (int t = 0; t < NUM_THREADS; t++)
                    if (gnt_oh[t]) tstate[t] <= T_INFLIGHT;
            end else begin
                bus.outState <= '0;
            end

            // Returning thread is never the granted one: grant needs READY
            if (ret_valid) begin
                if (tstate[ret_id] == T_INFLIGHT) begin
                    if (bus.ret_halt) begin
                        tstate[ret_id] <= T_DONE;
                    end else begin
                        tstate[ret_id] <= T_READY;
                        ctx[ret_id] <= bus.ret_state;
                    end
                end else begin
                    bus.err_ret <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_thread_issue.sv
// Scoreboard bench for thread_issue: directed launches, auto returns,
// bypass/halt/error scenarios.
module tb_thread_issue;
    import thread_issue_pkg::*;

    localparam int          NT = 8;
    localparam int          CW = 32;
    localparam logic [31:0] ADDR = 32'h0000_1000;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    thread_issue_if #(.NUM_THREADS(NT), .CNT_W(CW)) bus ();

    thread_issue #(
        .NUM_THREADS (NT),
        .addressStart(ADDR),
        .CNT_W       (CW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    typedef struct {
        int                     due;
        pipeline_pass_structure ctx;
        logic                   halt;
    } ret_rec_t;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    bit auto_ret = 1'b0;
    int rounds [NT];
    pipeline_pass_structure sb [$];
    ret_rec_t retq [$];

    function automatic pipeline_pass_structure mk(
        input int id, input logic [31:0] pc, input logic [31:0] data
    );
        pipeline_pass_structure s;
        s = '0;
        s.system.active_thread = 1'b1;
        s.system.id = SYS_ID_W'(id);
        s.pc = pc;
        s.data = data;
        return s;
    endfunction

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_sb(input int maxc, input string name);
        int k = 0;
        while (sb.size() != 0 && k < maxc) begin
            tick(1);
            k++;
        end
        chk(name, 64'(sb.size()), 64'd0);
    endtask

    task automatic wait_done(input int maxc, input string name);
        int k = 0;
        @(negedge clk);
        while (bus.done !== 1'b1 && k < maxc) begin
            @(negedge clk);
            k++;
        end
        chk(name, 64'(bus.done), 64'd1);
        chk({name, "_busy"}, 64'(bus.busy), 64'd0);
        @(negedge clk);
        chk({name, "_pulse"}, 64'(bus.done), 64'd0);
        tick(1);
    endtask

    task automatic start_run(input logic [NT-1:0] mask);
        bus.launch_mask = mask;
        bus.start = 1'b1;
        tick(1);
        bus.start = 1'b0;
        bus.launch_mask = '0;
    endtask

    task automatic ret_manual(input int id, input logic [31:0] pc,
                              input logic [31:0] data, input logic halt);
        bus.ret_state = mk(id, pc, data);
        bus.ret_halt = halt;
        tick(1);
        bus.ret_state = '0;
        bus.ret_halt = 1'b0;
    endtask

    task automatic chk_reset(input string name);
        chk({name, "_out"}, 64'(bus.outState == '0), 64'd1);
        chk({name, "_busy"}, 64'(bus.busy), 64'd0);
        chk({name, "_done"}, 64'(bus.done), 64'd0);
        chk({name, "_err"}, 64'(bus.err_ret), 64'd0);
        chk({name, "_icnt"}, 64'(bus.issue_count), 64'd0);
        chk({name, "_rcyc"}, 64'(bus.run_cycles), 64'd0);
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Monitor: every issued structure must match the scoreboard head
    initial forever begin
        pipeline_pass_structure expv;
        ret_rec_t r;
        int id;
        @(negedge clk);
        if (bus.outState.system.active_thread === 1'b1) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_issue: got %h expected none",
                         bus.outState);
            end else begin
                expv = sb.pop_front();
                if (bus.outState !== expv) begin
                    errors++;
                    $display("FAIL issue: got %h expected %h",
                             bus.outState, expv);
                end
            end
            if (auto_ret) begin
                id = int'(bus.outState.system.id);
                r.ctx = bus.outState;
                r.ctx.pc = r.ctx.pc + 32'd4;
                r.ctx.data = r.ctx.data + 32'd1;
                r.halt = (rounds[id] >= 1);
                r.due = cyc + 3;
                rounds[id]++;
                retq.push_back(r);
            end
        end
    end

    // Auto returner: a non-halting return predicts the next issue
    initial forever begin
        ret_rec_t r;
        @(posedge clk);
        #1;
        if (auto_ret) begin
            if (retq.size() > 0 && retq[0].due <= cyc) begin
                r = retq.pop_front();
                bus.ret_state = r.ctx;
                bus.ret_halt = r.halt;
                if (!r.halt) sb.push_back(r.ctx);
            end else begin
                bus.ret_state = '0;
                bus.ret_halt = 1'b0;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        bus.start = 1'b0;
        bus.launch_mask = '0;
        bus.issue_en = 1'b1;
        bus.ret_state = '0;
        bus.ret_halt = 1'b0;
        for (int t = 0; t < NT; t++) rounds[t] = 0;

        rst = 1'b0;
        tick(2);
        @(negedge clk);
        chk_reset("por");
        tick(1);
        rst = 1'b1;
        tick(1);

        // Launch threads 0 and 2, no returns
        sb.push_back(mk(0, ADDR, 0));
        sb.push_back(mk(2, ADDR, 0));
        start_run(8'b0000_0101);
        wait_sb(10, "t2_issue");
        tick(3);
        @(negedge clk);
        chk("t2_icnt", 64'(bus.issue_count), 64'd2);
        chk("t2_busy", 64'(bus.busy), 64'd1);
        chk("t2_bubble", 64'(bus.outState == '0), 64'd1);
        tick(1);

        // Mid-run reset
        rst = 1'b0;
        tick(2);
        @(negedge clk);
        chk_reset("midrst");
        tick(1);
        rst = 1'b1;

        // Return for a thread that is not in flight
        ret_manual(5, 32'hDEAD, 32'h0, 1'b0);
        @(negedge clk);
        chk("t6_err", 64'(bus.err_ret), 64'd1);
        tick(3);
        @(negedge clk);
        chk("t6_sticky", 64'(bus.err_ret), 64'd1);
        chk("t6_busy", 64'(bus.busy), 64'd0);
        chk("t6_icnt", 64'(bus.issue_count), 64'd0);
        tick(1);
        rst = 1'b0;
        tick(2);
        rst = 1'b1;
        @(negedge clk);
        chk("t6_clr", 64'(bus.err_ret), 64'd0);
        tick(1);

        // Round robin with recirculation, halt on second pass
        auto_ret = 1'b1;
        for (int t = 0; t < NT; t++) sb.push_back(mk(t, ADDR, 0));
        start_run(8'hFF);
        wait_sb(80, "t3_rr");
        wait_done(80, "t3_done");
        chk("t3_icnt", 64'(bus.issue_count), 64'd16);
        chk("t3_retq", 64'(retq.size()), 64'd0);
        auto_ret = 1'b0;
        tick(1);

        // Same-cycle return and issue: no bypass
        sb.push_back(mk(1, ADDR, 0));
        start_run(8'h02);
        wait_sb(10, "t4_first");
        tick(2);
        ret_manual(1, 32'h2000, 32'hAB, 1'b0);
        sb.push_back(mk(1, 32'h2000, 32'hAB));
        @(negedge clk);
        chk("t4_no_bypass", 64'(bus.outState.system.active_thread), 64'd0);
        wait_sb(5, "t4_reissue");
        ret_manual(1, 32'h2004, 32'hAC, 1'b1);
        wait_done(10, "t4_done");
        chk("t4_icnt", 64'(bus.issue_count), 64'd2);

        // Halt/done timing, start ignored while running
        sb.push_back(mk(0, ADDR, 0));
        sb.push_back(mk(1, ADDR, 0));
        start_run(8'h03);
        wait_sb(10, "t5_issue");
        bus.launch_mask = 8'hFF;
        bus.start = 1'b1;
        tick(1);
        bus.start = 1'b0;
        bus.launch_mask = '0;
        tick(2);
        @(negedge clk);
        chk("t5_ignore_start", 64'(bus.outState == '0), 64'd1);
        chk("t5_busy_run", 64'(bus.busy), 64'd1);
        tick(1);
        ret_manual(0, 32'h3000, 32'h0, 1'b1);
        ret_manual(1, 32'h3000, 32'h0, 1'b1);
        @(negedge clk);
        chk("t5_done_early", 64'(bus.done), 64'd0);
        chk("t5_busy_early", 64'(bus.busy), 64'd1);
        @(negedge clk);
        chk("t5_done", 64'(bus.done), 64'd1);
        chk("t5_busy_drop", 64'(bus.busy), 64'd0);
        @(negedge clk);
        chk("t5_done_pulse", 64'(bus.done), 64'd0);
        chk("t5_icnt", 64'(bus.issue_count), 64'd2);
        chk("t5_err", 64'(bus.err_ret), 64'd0);
        tick(3);
        chk("final_sb", 64'(sb.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
